mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 25 ++
 rtl/mem_rdata_hold.sv | 42 ++++
 rtl/mem_stage.sv | 92 +++++++++
 tb/tb_mem_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: bus widths used by EXE, MEM and WB, and
// the packed layouts of the EXE->MEM and MEM->WB buses.
package mem_stage_pkg;

    localparam int unsigned MYCPU_EXE_TO_MEM_BUS_WD = 73;
    localparam int unsigned MYCPU_MEM_TO_WB_BUS_WD  = 70;

    typedef struct packed {
        logic        inst_ld_w;
        logic        inst_lu12i_w;
        logic        load_op;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } exe_to_mem_bus_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } mem_to_wb_bus_t;

endpackage

// File: rtl/mem_rdata_hold.sv
// Tracks the first cycle of MEM occupancy and keeps SRAM load data alive
// across WB back-pressure, since the SRAM only drives it for one cycle.
module mem_rdata_hold (
    input  logic        clk,
    input  logic        reset,
    input  logic        capture_i,
    input  logic        mem_valid_i,
    input  logic        load_op_i,
    input  logic        wb_allowin_i,
    input  logic [31:0] rdata_i,
    output logic        fresh_o,
    output logic [31:0] rdata_hold_o
);

    logic        fresh_q, fresh_d;
    logic [31:0] rdata_hold_q, rdata_hold_d;

    // Next-state: fresh follows each capture; hold grabs rdata only when a
    // fresh load is about to stall.
    always_comb begin
        fresh_d      = capture_i;
        rdata_hold_d = rdata_hold_q;
        if (fresh_q && mem_valid_i && load_op_i && !wb_allowin_i) begin
            rdata_hold_d = rdata_i;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fresh_q      <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            fresh_q      <= fresh_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign fresh_o      = fresh_q;
    assign rdata_hold_o = rdata_hold_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: single-entry buffer between EXE and WB, selects the
// final result (SRAM data for loads, ALU result otherwise) and exports
// bypass/hazard information.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned EXE_TO_MEM_BUS_WD = MYCPU_EXE_TO_MEM_BUS_WD,
    parameter int unsigned MEM_TO_WB_BUS_WD  = MYCPU_MEM_TO_WB_BUS_WD
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         exe_to_mem_valid,
    input  logic [EXE_TO_MEM_BUS_WD-1:0] exe_to_mem_bus,
    output logic                         mem_allowin,
    input  logic                         wb_allowin,
    output logic                         mem_to_wb_valid,
    output logic [MEM_TO_WB_BUS_WD-1:0]  mem_to_wb_bus,
    input  logic [31:0]                  data_sram_rdata,
    output logic                         mem_fwd_valid,
    output logic [4:0]                   mem_fwd_dest,
    output logic [31:0]                  mem_fwd_result,
    output logic                         mem_fwd_is_load
);

    logic                         mem_valid_q, mem_valid_d;
    logic [EXE_TO_MEM_BUS_WD-1:0] bus_q, bus_d;
    logic                         capture;
    logic                         fresh;
    logic [31:0]                  rdata_hold;
    logic [31:0]                  final_result;
    exe_to_mem_bus_t              bus_s;
    mem_to_wb_bus_t               wb_s;
    logic                         unused_bus_bits;

    assign bus_s           = bus_q;
    assign unused_bus_bits = ^{bus_s.inst_ld_w, bus_s.inst_lu12i_w};

    // Handshake and next-state: ready_go is always 1, so MEM accepts whenever
    // it is empty or WB is draining it this cycle.
    always_comb begin
        mem_allowin = !mem_valid_q || wb_allowin;
        capture     = exe_to_mem_valid && mem_allowin;
        mem_valid_d = mem_allowin ? exe_to_mem_valid : mem_valid_q;
        bus_d       = capture ? exe_to_mem_bus : bus_q;
    end

    // Stage valid and bus register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q <= 1'b0;
            bus_q       <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            bus_q       <= bus_d;
        end
    end

    mem_rdata_hold u_rdata_hold (
        .clk          (clk),
        .reset        (reset),
        .capture_i    (capture),
        .mem_valid_i  (mem_valid_q),
        .load_op_i    (bus_s.load_op),
        .wb_allowin_i (wb_allowin),
        .rdata_i      (data_sram_rdata),
        .fresh_o      (fresh),
        .rdata_hold_o (rdata_hold)
    );

    // Result select: live SRAM data only in the first cycle, held copy after.
    always_comb begin
        if (bus_s.load_op) begin
            final_result = fresh ? data_sram_rdata : rdata_hold;
        end else begin
            final_result = bus_s.alu_result;
        end
    end

    assign wb_s.gr_we        = bus_s.gr_we;
    assign wb_s.dest         = bus_s.dest;
    assign wb_s.final_result = final_result;
    assign wb_s.pc           = bus_s.pc;

    assign mem_to_wb_valid = mem_valid_q;
    assign mem_to_wb_bus   = wb_s;

    assign mem_fwd_valid   = mem_valid_q && bus_s.gr_we && (bus_s.dest != 5'd0);
    assign mem_fwd_dest    = bus_s.dest;
    assign mem_fwd_result  = final_result;
    assign mem_fwd_is_load = mem_valid_q && bus_s.load_op;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        exe_to_mem_valid;
    logic [72:0] exe_to_mem_bus;
    logic        mem_allowin;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [69:0] mem_to_wb_bus;
    logic [31:0] data_sram_rdata;
    logic        mem_fwd_valid;
    logic [4:0]  mem_fwd_dest;
    logic [31:0] mem_fwd_result;
    logic        mem_fwd_is_load;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage #(
        .EXE_TO_MEM_BUS_WD(73),
        .MEM_TO_WB_BUS_WD (70)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .exe_to_mem_valid (exe_to_mem_valid),
        .exe_to_mem_bus   (exe_to_mem_bus),
        .mem_allowin      (mem_allowin),
        .wb_allowin       (wb_allowin),
        .mem_to_wb_valid  (mem_to_wb_valid),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .data_sram_rdata  (data_sram_rdata),
        .mem_fwd_valid    (mem_fwd_valid),
        .mem_fwd_dest     (mem_fwd_dest),
        .mem_fwd_result   (mem_fwd_result),
        .mem_fwd_is_load  (mem_fwd_is_load)
    );

    function automatic logic [72:0] mk_bus(input logic ld, input logic lu, input logic load,
                                           input logic we, input logic [4:0] dest,
                                           input logic [31:0] alu, input logic [31:0] pc);
        return {ld, lu, load, we, dest, alu, pc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; exe_to_mem_valid = 1'b0; wb_allowin = 1'b1;
        exe_to_mem_bus = '0; data_sram_rdata = '0;
        step(); step();
        settle();
        n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", mem_to_wb_valid); end
        n_checks++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL rst_allowin: got %b expected 1", mem_allowin); end
        n_checks++; if (mem_fwd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fwd_valid: got %b expected 0", mem_fwd_valid); end
        n_checks++; if (mem_fwd_is_load !== 1'b0) begin n_fail++; $display("FAIL rst_fwd_is_load: got %b expected 0", mem_fwd_is_load); end
        n_checks++; if (mem_to_wb_bus !== 70'h0) begin n_fail++; $display("FAIL rst_bus: got %h expected 0", mem_to_wb_bus); end
        step();
        reset = 1'b0;
    endtask

    task automatic test_alu_op();
        wb_allowin = 1'b1;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus = mk_bus(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h12345678, 32'h1c000000);
        settle();
        n_checks++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL alu_allowin: got %b expected 1", mem_allowin); end
        step();
        exe_to_mem_valid = 1'b0;
        settle();
        n_checks++; if (mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid: got %b expected 1", mem_to_wb_valid); end
        n_checks++; if (mem_to_wb_bus[63:32] !== 32'h12345678) begin n_fail++; $display("FAIL alu_result: got %h expected 12345678", mem_to_wb_bus[63:32]); end
        n_checks++; if (mem_to_wb_bus[68:64] !== 5'd5) begin n_fail++; $display("FAIL alu_dest: got %0d expected 5", mem_to_wb_bus[68:64]); end
        n_checks++; if (mem_to_wb_bus[69] !== 1'b1) begin n_fail++; $display("FAIL alu_gr_we: got %b expected 1", mem_to_wb_bus[69]); end
        n_checks++; if (mem_to_wb_bus[31:0] !== 32'h1c000000) begin n_fail++; $display("FAIL alu_pc: got %h expected 1c000000", mem_to_wb_bus[31:0]); end
        n_checks++; if (mem_fwd_valid !== 1'b1) begin n_fail++; $display("FAIL alu_fwd_valid: got %b expected 1", mem_fwd_valid); end
        n_checks++; if (mem_fwd_dest !== 5'd5) begin n_fail++; $display("FAIL alu_fwd_dest: got %0d expected 5", mem_fwd_dest); end
        n_checks++; if (mem_fwd_result !== 32'h12345678) begin n_fail++; $display("FAIL alu_fwd_result: got %h expected 12345678", mem_fwd_result); end
        n_checks++; if (mem_fwd_is_load !== 1'b0) begin n_fail++; $display("FAIL alu_fwd_is_load: got %b expected 0", mem_fwd_is_load); end
        step();
        settle();
        n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_drain: got %b expected 0", mem_to_wb_valid); end
        step();
    endtask

    task automatic test_load_stall();
        wb_allowin = 1'b0;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus = mk_bus(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h00000100, 32'h1c000010);
        step();
        exe_to_mem_valid = 1'b0;
        data_sram_rdata = 32'hDEADBEEF;
        settle();
        n_checks++; if (mem_to_wb_bus[63:32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_fresh_result: got %h expected deadbeef", mem_to_wb_bus[63:32]); end
        n_checks++; if (mem_fwd_is_load !== 1'b1) begin n_fail++; $display("FAIL ld_fwd_is_load: got %b expected 1", mem_fwd_is_load); end
        n_checks++; if (mem_allowin !== 1'b0) begin n_fail++; $display("FAIL ld_allowin: got %b expected 0", mem_allowin); end
        n_checks++; if (mem_fwd_result !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_fwd_result: got %h expected deadbeef", mem_fwd_result); end
        step();
        data_sram_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++; if (mem_to_wb_bus[63:32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_stall_result[%0d]: got %h expected deadbeef", i, mem_to_wb_bus[63:32]); end
            n_checks++; if (mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL ld_stall_valid[%0d]: got %b expected 1", i, mem_to_wb_valid); end
            step();
        end
        wb_allowin = 1'b1;
        settle();
        n_checks++; if (mem_to_wb_bus[63:32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_release_result: got %h expected deadbeef", mem_to_wb_bus[63:32]); end
        n_checks++; if (mem_to_wb_bus[68:64] !== 5'd7) begin n_fail++; $display("FAIL ld_release_dest: got %0d expected 7", mem_to_wb_bus[68:64]); end
        n_checks++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL ld_release_allowin: got %b expected 1", mem_allowin); end
        step();
        settle();
        n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL ld_drain: got %b expected 0", mem_to_wb_valid); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        wb_allowin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exe_to_mem_valid = 1'b1;
            exe_to_mem_bus = mk_bus(1'b0, 1'b0, 1'b0, 1'b1, 5'(i + 1), 32'h000000A0 + 32'(i),
                                    32'h1c000100 + 32'(4 * i));
            settle();
            n_checks++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL b2b_allowin[%0d]: got %b expected 1", i, mem_allowin); end
            if (i > 0) begin
                exp_pc = 32'h1c000100 + 32'(4 * (i - 1));
                n_checks++; if (mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i - 1, mem_to_wb_valid); end
                n_checks++; if (mem_to_wb_bus[31:0] !== exp_pc) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i - 1, mem_to_wb_bus[31:0], exp_pc); end
            end
            step();
        end
        exe_to_mem_valid = 1'b0;
        settle();
        n_checks++; if (mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[3]: got %b expected 1", mem_to_wb_valid); end
        n_checks++; if (mem_to_wb_bus[31:0] !== 32'h1c00010c) begin n_fail++; $display("FAIL b2b_pc[3]: got %h expected 1c00010c", mem_to_wb_bus[31:0]); end
        n_checks++; if (mem_to_wb_bus[63:32] !== 32'h000000A3) begin n_fail++; $display("FAIL b2b_result[3]: got %h expected 000000a3", mem_to_wb_bus[63:32]); end
        step();
        settle();
        n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", mem_to_wb_valid); end
        step();
    endtask

    task automatic test_dest_zero();
        wb_allowin = 1'b1;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus = mk_bus(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h00000055, 32'h1c000200);
        step();
        exe_to_mem_valid = 1'b0;
        settle();
        n_checks++; if (mem_fwd_valid !== 1'b0) begin n_fail++; $display("FAIL dz_fwd_valid: got %b expected 0", mem_fwd_valid); end
        n_checks++; if (mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL dz_valid: got %b expected 1", mem_to_wb_valid); end
        step();
    endtask

    task automatic test_stall_hold();
        wb_allowin = 1'b1;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus = mk_bus(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h00001111, 32'h1c000300);
        step();
        wb_allowin = 1'b0;
        exe_to_mem_bus = mk_bus(1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h00002222, 32'h1c000304);
        settle();
        n_checks++; if (mem_allowin !== 1'b0) begin n_fail++; $display("FAIL sh_allowin: got %b expected 0", mem_allowin); end
        n_checks++; if (mem_to_wb_bus[31:0] !== 32'h1c000300) begin n_fail++; $display("FAIL sh_pc0: got %h expected 1c000300", mem_to_wb_bus[31:0]); end
        step();
        settle();
        n_checks++; if (mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL sh_valid: got %b expected 1", mem_to_wb_valid); end
        n_checks++; if (mem_to_wb_bus[31:0] !== 32'h1c000300) begin n_fail++; $display("FAIL sh_pc1: got %h expected 1c000300", mem_to_wb_bus[31:0]); end
        n_checks++; if (mem_to_wb_bus[63:32] !== 32'h00001111) begin n_fail++; $display("FAIL sh_result: got %h expected 00001111", mem_to_wb_bus[63:32]); end
        step();
        wb_allowin = 1'b1;
        settle();
        n_checks++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL sh_release_allowin: got %b expected 1", mem_allowin); end
        step();
        exe_to_mem_valid = 1'b0;
        settle();
        n_checks++; if (mem_to_wb_bus[31:0] !== 32'h1c000304) begin n_fail++; $display("FAIL sh_next_pc: got %h expected 1c000304", mem_to_wb_bus[31:0]); end
        n_checks++; if (mem_to_wb_bus[63:32] !== 32'h00002222) begin n_fail++; $display("FAIL sh_next_result: got %h expected 00002222", mem_to_wb_bus[63:32]); end
        step();
        settle();
        n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL sh_drain: got %b expected 0", mem_to_wb_valid); end
        step();
    endtask

    task automatic test_reset_mid_stall();
        wb_allowin = 1'b0;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus = mk_bus(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h00000200, 32'h1c000400);
        step();
        exe_to_mem_valid = 1'b0;
        data_sram_rdata = 32'hCAFEF00D;
        step();
        data_sram_rdata = 32'h0;
        settle();
        n_checks++; if (mem_to_wb_bus[63:32] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rms_held: got %h expected cafef00d", mem_to_wb_bus[63:32]); end
        step();
        reset = 1'b1;
        step();
        settle();
        n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL rms_valid: got %b expected 0", mem_to_wb_valid); end
        n_checks++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL rms_allowin: got %b expected 1", mem_allowin); end
        n_checks++; if (mem_fwd_valid !== 1'b0) begin n_fail++; $display("FAIL rms_fwd_valid: got %b expected 0", mem_fwd_valid); end
        n_checks++; if (mem_to_wb_bus !== 70'h0) begin n_fail++; $display("FAIL rms_bus: got %h expected 0", mem_to_wb_bus); end
        step();
        reset = 1'b0;
        wb_allowin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL rms_post[%0d]: got %b expected 0", i, mem_to_wb_valid); end
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu_op();
        test_load_stall();
        test_back_to_back();
        test_dest_zero();
        test_stall_hold();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
